// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_pkg                                                      |
// | Description : Shared definitions for the sequential 8-bit divider:         |
// |               operand width constant and FSM state encoding.               |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package alu_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/subtractor_9bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : subtractor_9bit                                              |
// | Description : Combinational 9-bit subtractor diff = a - b with borrow-out, |
// |               built as a generate/propagate borrow chain.                  |
// | Ports       : a, b   - 9-bit minuend / subtrahend                          |
// |               diff   - 9-bit difference (modulo 2^9)                       |
// |               borrow - 1 when a < b (unsigned)                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module subtractor_9bit (
    input  logic [8:0] a,
    input  logic [8:0] b,
    output logic [8:0] diff,
    output logic       borrow
);

    // chain[i] is the borrow into bit i; no borrow into the LSB.
    logic [9:0] chain;

    assign chain[0] = 1'b0;

    generate
        for (genvar i = 0; i < 9; i++) begin : g_bit
            logic brw_gen;
            logic brw_prop;

            // A bit generates a borrow when it subtracts 1 from 0, and passes an
            // incoming borrow through when its two operand bits are equal.
            assign brw_gen     = ~a[i] & b[i];
            assign brw_prop    = ~(a[i] ^ b[i]);
            assign diff[i]     = a[i] ^ b[i] ^ chain[i];
            assign chain[i+1]  = brw_gen | (brw_prop & chain[i]);
        end
    endgenerate

    assign borrow = chain[9];

endmodule : subtractor_9bit
`default_nettype wire

// File: rtl/alu_divider_8bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_divider_8bit                                             |
// | Description : Sequential unsigned restoring divider, one quotient bit per  |
// |               clock, MSB first. Divide-by-zero short-cuts straight to      |
// |               DONE with quotient all-ones and remainder = dividend.        |
// | Ports       : clk, rst_n (sync, active-low)                                |
// |               start, dividend, divisor  - request and operands             |
// |               busy        - high in RUN                                    |
// |               done        - one-cycle pulse in DONE                        |
// |               quotient, remainder, div_by_zero - held results              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_divider_8bit
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH   // only 8 is supported
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state;
    div_state_t       state_next;

    logic [3:0]       count;
    // Holds the dividend; each step shifts its MSB out into the partial
    // remainder and a new quotient bit in at the LSB, so after WIDTH steps it
    // contains the quotient.
    logic [WIDTH-1:0] dvd_shift;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH-1:0] partial;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] partial_next;
    logic [WIDTH-1:0] quot_next;
    logic             last_step;

    assign shifted = {partial, dvd_shift[WIDTH-1]};

    subtractor_9bit u_sub (
        .a      (shifted),
        .b      ({1'b0, dvs_reg}),
        .diff   (trial),
        .borrow (borrow)
    );

    // Restore on borrow: keep the shifted value, otherwise accept the trial.
    // When no borrow occurs the result is below the divisor, so bit WIDTH of
    // trial is always zero and may be dropped.
    assign partial_next = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quot_next    = {dvd_shift[WIDTH-2:0], ~borrow};
    assign last_step    = (count == 4'(WIDTH - 1));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers. Results are written only on the
    // edge that enters DONE, so they hold across IDLE and RUN.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count       <= 4'd0;
            dvd_shift   <= '0;
            dvs_reg     <= '0;
            partial     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            dvd_shift <= dividend;
                            dvs_reg   <= divisor;
                            partial   <= '0;
                            count     <= 4'd0;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    dvd_shift <= quot_next;
                    partial   <= partial_next;
                    count     <= count + 4'd1;
                    if (last_step) begin
                        quotient    <= quot_next;
                        remainder   <= partial_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : alu_divider_8bit
`default_nettype wire

// File: tb/tb_alu_divider_8bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_divider_8bit                                          |
// | Description : Self-checking bench for alu_divider_8bit: directed cases     |
// |               plus a randomized sweep against an arithmetic model.         |
// | Ports       : none                                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_divider_8bit;

    localparam int N_RANDOM = 4000;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int tests;
    int fails;

    alu_divider_8bit #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: plain integer division; zero divisor yields all-ones
    // quotient and the dividend as remainder.
    task automatic model(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r, output logic z);
        if (b == 8'd0) begin
            q = 8'hFF;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endtask

    // Start is applied just after edge N and dropped after edge N+1.
    // lat = k where done is first seen just after edge N+k (0 on timeout);
    // bcnt = number of post-edge samples with busy high.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           output int lat, output int bcnt);
        @(posedge clk); #1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        lat      = 0;
        bcnt     = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                start    = 1'b0;
                dividend = 8'($urandom);
                divisor  = 8'($urandom);
            end
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b);
        int lat, bcnt;
        logic [7:0] eq, er;
        logic ez;
        model(a, b, eq, er, ez);
        run_div(a, b, lat, bcnt);
        check({tag, "_latency"}, lat, (b == 0) ? 1 : 9);
        check({tag, "_busy_cycles"}, bcnt, (b == 0) ? 0 : 8);
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
        check({tag, "_dbz"}, div_by_zero, ez);
        @(posedge clk); #1;
        check({tag, "_done_width"}, done, 0);
        check({tag, "_hold_quotient"}, quotient, eq);
    endtask

    initial begin
        int lat, bcnt, n_done, first_k, second_k;
        logic saw_done;
        logic [7:0] a, b, eq, er;
        logic ez;

        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;

        // Reset, with start asserted to show reset wins.
        @(posedge clk); #1;
        start    = 1'b1;
        dividend = 8'd77;
        divisor  = 8'd3;
        @(posedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_outputs", {quotient, remainder, 7'd0, div_by_zero}, 0);
        start = 1'b0;
        rst_n = 1'b1;

        directed("d100_7", 8'd100, 8'd7);
        directed("d255_1", 8'd255, 8'd1);
        directed("d7_9", 8'd7, 8'd9);
        directed("d5_0", 8'd5, 8'd0);

        // 200/3 with a second request injected in RUN cycle 4.
        @(posedge clk); #1;
        start = 1'b1; dividend = 8'd200; divisor = 8'd3;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (k == 4) begin start = 1'b1; dividend = 8'd9; divisor = 8'd3; end
            if (k == 5) start = 1'b0;
            if (done) begin lat = k; break; end
        end
        check("ign_latency", lat, 9);
        check("ign_quotient", quotient, 66);
        check("ign_remainder", remainder, 2);
        @(posedge clk); #1;
        check("ign_no_relaunch", {busy, done}, 0);

        // Reset in RUN cycle 5 aborts the operation.
        @(posedge clk); #1;
        start = 1'b1; dividend = 8'd123; divisor = 8'd7;
        saw_done = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (done) saw_done = 1'b1;
        end
        check("abort_in_run", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_outputs", {quotient, remainder, 7'd0, div_by_zero}, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        directed("d50_5", 8'd50, 8'd5);

        // start held high relaunches on every return to IDLE.
        @(posedge clk); #1;
        start = 1'b1; dividend = 8'd20; divisor = 8'd4;
        n_done = 0; first_k = 0; second_k = 0;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                if (n_done == 1) first_k = k;
                if (n_done == 2) second_k = k;
            end
        end
        start = 1'b0;
        check("held_pulses", n_done, 2);
        check("held_gap", second_k - first_k, 10);
        check("held_quotient", quotient, 5);
        repeat (12) @(posedge clk);

        // Randomized sweep.
        for (int i = 0; i < N_RANDOM; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            model(a, b, eq, er, ez);
            run_div(a, b, lat, bcnt);
            check("rand_result", {quotient, remainder, 7'd0, div_by_zero}, {eq, er, 7'd0, ez});
            check("rand_latency", lat, (b == 0) ? 1 : 9);
            if (b != 0) begin
                check("rand_identity",
                      (32'(quotient) * 32'(b) + 32'(remainder) == 32'(a)) && (remainder < b), 1);
            end
            @(posedge clk); #1;
            check("rand_done_width", done, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_alu_divider_8bit
`default_nettype wire
